// File: rtl/time_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
package time_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2
  } mode_e;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Per-digit BCD increment of a two-digit field; returns 00 once the field reaches max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val >= max) begin
      res = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by an edge detector (any edge or rising edge only).
module sync_edge #(
  parameter int unsigned SyncStages = 2,
  parameter bit          RiseOnly   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic                  sync_out;

  assign sync_out = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      prev_q <= sync_out;
    end
  end

  assign edge_o = RiseOnly ? (sync_out & ~prev_q) : (sync_out ^ prev_q);

endmodule

// File: rtl/time_counter.sv
// BCD hh:mm:ss counter driven by a toggling seconds signal, with a mode button to
// step through RUN / SET_HOUR / SET_MIN and an increment button for setting.
module time_counter
  import time_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pulse,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       day_wrap
);

  logic tick, mode_ev, inc_ev;

  sync_edge #(
    .SyncStages(SYNC_STAGES),
    .RiseOnly  (1'b0)
  ) u_sync_pulse (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (pulse),
    .edge_o(tick)
  );

  sync_edge #(
    .SyncStages(SYNC_STAGES),
    .RiseOnly  (1'b1)
  ) u_sync_mode (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (mode_btn),
    .edge_o(mode_ev)
  );

  sync_edge #(
    .SyncStages(SYNC_STAGES),
    .RiseOnly  (1'b1)
  ) u_sync_inc (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (inc_btn),
    .edge_o(inc_ev)
  );

  mode_e      state_q, state_d;
  logic [7:0] hours_q, hours_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       sec_tick_q, sec_tick_d;
  logic       day_wrap_q, day_wrap_d;

  always_comb begin
    state_d    = state_q;
    hours_d    = hours_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;

    case (state_q)
      StRun: begin
        if (tick) begin
          sec_tick_d = 1'b1;
          sec_d      = bcd_inc(sec_q, SEC_MAX);
          if (sec_q == SEC_MAX) begin
            min_d = bcd_inc(min_q, MIN_MAX);
            if (min_q == MIN_MAX) begin
              hours_d    = bcd_inc(hours_q, HOUR_MAX);
              day_wrap_d = (hours_q == HOUR_MAX);
            end
          end
        end
        // A coincident tick is still applied before leaving RUN.
        if (mode_ev) begin
          state_d = StSetHour;
        end
      end
      StSetHour: begin
        if (mode_ev) begin
          state_d = StSetMin;
        end else if (inc_ev) begin
          hours_d = bcd_inc(hours_q, HOUR_MAX);
        end
      end
      StSetMin: begin
        if (mode_ev) begin
          state_d = StRun;
          sec_d   = 8'h00;
        end else if (inc_ev) begin
          min_d = bcd_inc(min_q, MIN_MAX);
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StRun;
      hours_q    <= 8'h00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hours_q    <= hours_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign hours    = hours_q;
  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign mode     = state_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;

endmodule
